// File: rtl/periph_bridge_pkg.sv
// Shared types and constants for the single-master peripheral bridge.
// Imported by the order FIFO and the bridge top level.
package periph_bridge_pkg;

    typedef struct packed {
        logic       null_e;
        logic [3:0] sel;
    } ord_entry_t;

    localparam logic [63:0] TIMEOUT_DATA = '1;

    function automatic int sel_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/periph_bridge_rsp_order_fifo.sv
// In-order FIFO of outstanding read targets.
// Pointers wrap modulo DEPTH, which must be a power of two.
module rsp_order_fifo
    import periph_bridge_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter type entry_t = ord_entry_t
) (
    input  logic   clk_i,
    input  logic   rst_ni,
    input  logic   push_i,
    input  entry_t data_i,
    input  logic   pop_i,
    output logic   full_o,
    output logic   empty_o,
    output entry_t head_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    entry_t          mem_q [DEPTH];
    logic [PW-1:0]   wr_q, wr_d;
    logic [PW-1:0]   rd_q, rd_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            do_push, do_pop;

    assign full_o  = (cnt_q == CW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign head_o  = mem_q[rd_q];

    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (do_push) wr_d = wr_q + 1'b1;
        if (do_pop)  rd_d = rd_q + 1'b1;
        unique case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
            if (do_push) mem_q[wr_q] <= data_i;
        end
    end

endmodule

// File: rtl/periph_bridge.sv
// Single-master to NSLAVE bridge: address decode, in-order read return,
// response timeout and interrupt aggregation.
module periph_bridge
    import periph_bridge_pkg::*;
#(
    parameter int NSLAVE  = 4,
    parameter int WIDTH   = 32,
    parameter int SLV_AW  = 4,
    parameter int MAXPEND = 4,
    parameter int TIMEOUT = 255,
    localparam int SEL_W  = sel_w(NSLAVE),
    localparam int AW     = SEL_W + SLV_AW
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic [AW-1:0]           m_address,
    input  logic [WIDTH-1:0]        m_writedata,
    input  logic                    m_read,
    input  logic                    m_write,
    output logic                    m_waitrequest,
    output logic [WIDTH-1:0]        m_readdata,
    output logic                    m_readdatavalid,
    output logic                    m_error,
    output logic                    m_irq,
    output logic [SLV_AW-1:0]       s_address,
    output logic [WIDTH-1:0]        s_writedata,
    output logic [NSLAVE-1:0]       s_read,
    output logic [NSLAVE-1:0]       s_write,
    input  logic [NSLAVE-1:0]       s_waitrequest,
    input  logic [NSLAVE*WIDTH-1:0] s_readdata,
    input  logic [NSLAVE-1:0]       s_readdatavalid,
    input  logic [NSLAVE-1:0]       s_irq
);

    localparam int TW = 16;

    logic [SEL_W-1:0]  sel;
    logic              sel_ok;
    logic              swait;
    logic              fifo_full, fifo_empty;
    logic              push, pop;
    ord_entry_t        push_e, head;
    logic [NSLAVE-1:0] exp_mask;
    logic              head_rv;
    logic [WIDTH-1:0]  head_data;
    logic              null_pop, tmo_hit, unexp;

    logic [TW-1:0]     tmo_q, tmo_d;
    logic [WIDTH-1:0]  rdata_q, rdata_d;
    logic              rdv_q, rdv_d;
    logic              err_q, err_d;
    logic              irq_q, irq_d;

    assign sel         = m_address[AW-1 -: SEL_W];
    assign sel_ok      = (int'(sel) < NSLAVE);
    assign s_address   = m_address[SLV_AW-1:0];
    assign s_writedata = m_writedata;

    always_comb begin
        s_read  = '0;
        s_write = '0;
        swait   = 1'b0;
        for (int k = 0; k < NSLAVE; k++) begin
            if (sel_ok && int'(sel) == k) begin
                s_read[k]  = m_read & ~fifo_full;
                s_write[k] = m_write & ~m_read;
                swait      = s_waitrequest[k];
            end
        end
    end

    assign m_waitrequest = swait | (m_read & fifo_full);
    assign push          = m_read & ~m_waitrequest;
    assign push_e.null_e = ~sel_ok;
    assign push_e.sel    = 4'(sel);

    rsp_order_fifo #(
        .DEPTH   (MAXPEND),
        .entry_t (ord_entry_t)
    ) u_fifo (
        .clk_i   (clock),
        .rst_ni  (reset_n),
        .push_i  (push),
        .data_i  (push_e),
        .pop_i   (pop),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .head_o  (head)
    );

    // Only the head slave may respond; anything else is a stray response.
    always_comb begin
        exp_mask  = '0;
        head_rv   = 1'b0;
        head_data = '0;
        for (int k = 0; k < NSLAVE; k++) begin
            if (!fifo_empty && !head.null_e && head.sel == 4'(k)) begin
                exp_mask[k] = 1'b1;
                head_rv     = s_readdatavalid[k];
                head_data   = s_readdata[k*WIDTH +: WIDTH];
            end
        end
    end

    assign null_pop = ~fifo_empty & head.null_e;
    assign tmo_hit  = ~fifo_empty & ~head.null_e & ~head_rv
                    & (tmo_q == TW'(TIMEOUT - 1));
    assign pop      = head_rv | null_pop | tmo_hit;
    assign unexp    = |(s_readdatavalid & ~exp_mask);

    always_comb begin
        tmo_d   = tmo_q;
        rdata_d = rdata_q;
        rdv_d   = pop;
        err_d   = unexp | tmo_hit;
        irq_d   = |s_irq;
        if (pop) begin
            tmo_d = '0;
        end else if (!fifo_empty) begin
            tmo_d = tmo_q + 1'b1;
        end
        unique case (1'b1)
            head_rv:  rdata_d = head_data;
            tmo_hit:  rdata_d = TIMEOUT_DATA[WIDTH-1:0];
            null_pop: rdata_d = '0;
            default:  rdata_d = rdata_q;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            tmo_q   <= '0;
            rdata_q <= '0;
            rdv_q   <= 1'b0;
            err_q   <= 1'b0;
            irq_q   <= 1'b0;
        end else begin
            tmo_q   <= tmo_d;
            rdata_q <= rdata_d;
            rdv_q   <= rdv_d;
            err_q   <= err_d;
            irq_q   <= irq_d;
        end
    end

    assign m_readdata      = rdata_q;
    assign m_readdatavalid = rdv_q;
    assign m_error         = err_q;
    assign m_irq           = irq_q;

endmodule

// File: tb/tb_periph_bridge.sv
// Directed bench for periph_bridge with three slaves and a short timeout.
// Slave responses are driven cycle by cycle from the stimulus sequence.
module tb_periph_bridge;

    localparam int NS = 3;
    localparam int W  = 32;
    localparam int SA = 4;
    localparam int MP = 4;
    localparam int TO = 8;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic [5:0]    m_address;
    logic [W-1:0]  m_writedata;
    logic          m_read, m_write;
    logic          m_waitrequest;
    logic [W-1:0]  m_readdata;
    logic          m_readdatavalid, m_error, m_irq;
    logic [SA-1:0] s_address;
    logic [W-1:0]  s_writedata;
    logic [NS-1:0] s_read, s_write;
    logic [NS-1:0] s_waitrequest;
    logic [NS*W-1:0] s_readdata;
    logic [NS-1:0] s_readdatavalid;
    logic [NS-1:0] s_irq;

    int n_chk = 0;
    int n_fail = 0;
    int acc;

    always #5 clock = ~clock;

    periph_bridge #(
        .NSLAVE (NS), .WIDTH (W), .SLV_AW (SA),
        .MAXPEND (MP), .TIMEOUT (TO)
    ) dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .m_address       (m_address),
        .m_writedata     (m_writedata),
        .m_read          (m_read),
        .m_write         (m_write),
        .m_waitrequest   (m_waitrequest),
        .m_readdata      (m_readdata),
        .m_readdatavalid (m_readdatavalid),
        .m_error         (m_error),
        .m_irq           (m_irq),
        .s_address       (s_address),
        .s_writedata     (s_writedata),
        .s_read          (s_read),
        .s_write         (s_write),
        .s_waitrequest   (s_waitrequest),
        .s_readdata      (s_readdata),
        .s_readdatavalid (s_readdatavalid),
        .s_irq           (s_irq)
    );

    task automatic chk(input string tag, input logic [W-1:0] got,
                       input logic [W-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #2;
    endtask

    task automatic idle();
        m_read = 1'b0;
        m_write = 1'b0;
        s_readdatavalid = '0;
    endtask

    task automatic rsp(input int k, input logic [W-1:0] d);
        s_readdatavalid[k] = 1'b1;
        s_readdata[k*W +: W] = d;
    endtask

    function automatic logic [5:0] adr(input int sel, input int a);
        return 6'((sel << 4) | a);
    endfunction

    initial begin
        int sq [4];
        sq = '{0, 1, 2, 1};
        idle();
        m_address = '0;
        m_writedata = '0;
        s_waitrequest = '0;
        s_readdata = '0;
        s_irq = '0;
        #12;
        chk("rst_rdv", m_readdatavalid, 0);
        chk("rst_err", m_error, 0);
        chk("rst_irq", m_irq, 0);
        chk("rst_rdata", m_readdata, 0);
        reset_n = 1'b1;
        step();

        // write then read back through a 1-cycle slave
        m_write = 1; m_address = adr(0, 0); m_writedata = 32'h5A;
        #1;
        chk("wr_strobe", s_write, 1);
        chk("wr_wait", m_waitrequest, 0);
        chk("wr_data", s_writedata, 32'h5A);
        chk("wr_addr", s_address, 0);
        step();
        idle();
        m_read = 1; m_address = adr(0, 0);
        #1;
        chk("wr_once", s_write, 0);
        chk("rd_strobe", s_read, 1);
        step();
        idle();
        rsp(0, 32'h5A);
        #1;
        chk("rd_p1_rdv", m_readdatavalid, 0);
        step();
        idle();
        chk("rd_p2_rdv", m_readdatavalid, 1);
        chk("rd_p2_data", m_readdata, 32'h5A);
        chk("rd_p2_err", m_error, 0);
        step();
        chk("rd_p3_rdv", m_readdatavalid, 0);

        // write to a nonexistent slave is swallowed
        m_write = 1; m_address = adr(3, 5);
        #1;
        chk("inv_wr_strobe", s_write, 0);
        chk("inv_wr_wait", m_waitrequest, 0);
        chk("inv_wr_addr", s_address, 5);
        step();
        idle();

        // fill the FIFO, stall the fifth read, return in order
        for (int i = 0; i < 4; i++) begin
            m_read = 1; m_address = adr(sq[i], i);
            #1;
            chk("fill_wait", m_waitrequest, 0);
            step();
        end
        m_read = 1; m_address = adr(0, 7);
        #1;
        chk("full_wait", m_waitrequest, 1);
        chk("full_sread", s_read, 0);
        step();
        rsp(0, 32'hA0);
        #1;
        chk("full_wait2", m_waitrequest, 1);
        step();
        s_readdatavalid = '0;
        rsp(1, 32'hA1);
        #1;
        chk("pop_wait", m_waitrequest, 0);
        chk("ord0_rdv", m_readdatavalid, 1);
        chk("ord0_data", m_readdata, 32'hA0);
        step();
        m_read = 0;
        s_readdatavalid = '0;
        rsp(2, 32'hA2);
        chk("ord1_data", m_readdata, 32'hA1);
        step();
        s_readdatavalid = '0;
        rsp(1, 32'hA3);
        chk("ord2_data", m_readdata, 32'hA2);
        step();
        s_readdatavalid = '0;
        rsp(0, 32'hA4);
        chk("ord3_data", m_readdata, 32'hA3);
        step();
        idle();
        chk("ord4_rdv", m_readdatavalid, 1);
        chk("ord4_data", m_readdata, 32'hA4);
        chk("ord_err", m_error, 0);
        step();
        chk("ord_done", m_readdatavalid, 0);

        // null read queued behind a real one
        m_read = 1; m_address = adr(1, 0);
        step();
        m_read = 1; m_address = adr(3, 0);
        #1;
        chk("null_wait", m_waitrequest, 0);
        chk("null_sread", s_read, 0);
        step();
        idle();
        chk("null_hold1", m_readdatavalid, 0);
        step();
        chk("null_hold2", m_readdatavalid, 0);
        rsp(1, 32'hB1);
        step();
        idle();
        chk("null_real_rdv", m_readdatavalid, 1);
        chk("null_real_data", m_readdata, 32'hB1);
        step();
        chk("null_rdv", m_readdatavalid, 1);
        chk("null_data", m_readdata, 0);
        chk("null_err", m_error, 0);
        step();
        chk("null_done", m_readdatavalid, 0);

        // stray response alongside a valid head response
        m_read = 1; m_address = adr(0, 1);
        step();
        idle();
        rsp(0, 32'hC0);
        rsp(1, 32'hDEAD);
        step();
        idle();
        chk("stray_rdv", m_readdatavalid, 1);
        chk("stray_data", m_readdata, 32'hC0);
        chk("stray_err", m_error, 1);
        step();
        chk("stray_err_end", m_error, 0);

        // slave 2 never answers
        m_read = 1; m_address = adr(2, 3);
        step();
        idle();
        for (int i = 0; i < TO; i++) begin
            chk("tmo_wait", m_readdatavalid, 0);
            step();
        end
        chk("tmo_rdv", m_readdatavalid, 1);
        chk("tmo_data", m_readdata, 32'hFFFF_FFFF);
        chk("tmo_err", m_error, 1);
        step();
        chk("tmo_err_end", m_error, 0);
        rsp(2, 32'h22);
        step();
        idle();
        chk("late_err", m_error, 1);
        chk("late_rdv", m_readdatavalid, 0);
        step();

        // write stalled by slave 1 for three cycles
        acc = 0;
        m_write = 1; m_address = adr(1, 2); m_writedata = 32'h77;
        s_waitrequest = 3'b010;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("wstall_wait", m_waitrequest, 1);
            if (s_write[1] && !m_waitrequest) acc++;
            step();
        end
        s_waitrequest = '0;
        #1;
        chk("wstall_go", m_waitrequest, 0);
        chk("wstall_strobe", s_write, 3'b010);
        if (s_write[1] && !m_waitrequest) acc++;
        step();
        idle();
        chk("wstall_accepts", acc, 1);

        // interrupt aggregation
        s_irq = 3'b100;
        #1;
        chk("irq_delay", m_irq, 0);
        step();
        chk("irq_set", m_irq, 1);

        // async reset with two reads outstanding
        m_read = 1; m_address = adr(0, 0);
        step();
        m_address = adr(1, 0);
        step();
        idle();
        chk("pre_rst_data", m_readdata, 32'hFFFF_FFFF);
        #3;
        reset_n = 1'b0;
        #1;
        chk("arst_data", m_readdata, 0);
        chk("arst_irq", m_irq, 0);
        chk("arst_rdv", m_readdatavalid, 0);
        chk("arst_err", m_error, 0);
        step();
        reset_n = 1'b1;
        rsp(0, 32'h1234);
        step();
        idle();
        chk("stale_err", m_error, 1);
        chk("stale_rdv", m_readdatavalid, 0);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
